// File: rtl/imm_extend_queue_if.sv
// Handshake bundle between instruction decode (producer) and the ALU-B mux
// side (consumer) of the immediate-extension queue.
//
// Handshake rules (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   A producer holding valid=1 keeps its payload stable until the transfer.
//   The queue never makes in_ready depend on out_ready in the same cycle, and
//   out_data/out_mode stay stable while out_valid && !out_ready.
//   flush is a synchronous clear that overrides both sides for one cycle.
interface imm_extend_queue_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_imm;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [1:0]        out_mode;
  logic [CNT_W-1:0]  count;

  // Environment side: drives immediates, flush and consumer ready.
  modport master (
    output flush,
    output in_valid,
    output in_imm,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_mode,
    input  count
  );

  // Queue side.
  modport slave (
    input  flush,
    input  in_valid,
    input  in_imm,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_mode,
    output count
  );
endinterface

// File: rtl/imm_extend_queue.sv
// Immediate-extension unit with a small registered FIFO on its output.
// The immediate is extended combinationally according to in_mode and the
// result is written into the queue on a push; the head entry drives
// out_data/out_mode directly from storage. The only state is the storage
// array, the read/write pointers, the occupancy count and a one-bit flag
// that keeps in_ready low until the first clock after reset release.
module imm_extend_queue #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imm_extend_queue_if.slave    q
);

  // A single-entry queue still needs a one-bit pointer to keep types legal.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] MODE_SEXT  = 2'b00;
  localparam logic [1:0] MODE_ZEXT  = 2'b01;
  localparam logic [1:0] MODE_BRSH  = 2'b10;
  localparam logic [1:0] MODE_UPPER = 2'b11;

  // Storage and bookkeeping registers.
  logic [OUT_W-1:0] data_q [DEPTH];
  logic [1:0]       mode_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ready_en_q;

  // Combinational helpers.
  logic [OUT_W-1:0] sext_w;
  logic [OUT_W-1:0] ext_w;
  logic             in_ready_w;
  logic             push_w;
  logic             pop_w;
  logic             not_full_w;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Extend the incoming immediate according to the requested mode.
  always_comb begin
    sext_w = {{(OUT_W-IN_W){q.in_imm[IN_W-1]}}, q.in_imm};
    ext_w  = sext_w;
    case (q.in_mode)
      MODE_SEXT:  ext_w = sext_w;
      MODE_ZEXT:  ext_w = {{(OUT_W-IN_W){1'b0}}, q.in_imm};
      MODE_BRSH:  ext_w = {sext_w[OUT_W-3:0], 2'b00};
      MODE_UPPER: ext_w = {q.in_imm, {(OUT_W-IN_W){1'b0}}};
      default:    ext_w = sext_w;
    endcase
  end

  // in_ready uses only the registered count, never out_ready, so a full
  // queue refuses a push even if the head is popped in the same cycle.
  assign not_full_w = (count_q < CNT_W'(DEPTH));
  assign in_ready_w = ready_en_q && !q.flush && not_full_w;
  assign push_w     = q.in_valid && in_ready_w;
  assign pop_w      = (count_q != '0) && q.out_ready;

  // Next-state for pointers and occupancy; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_w) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop_w) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Register pointers, count and the post-reset ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_en_q <= 1'b1;
    end
  end

  // Write the extended operand and its mode into the slot at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        mode_q[i] <= '0;
      end
    end else if (push_w) begin
      data_q[wr_ptr_q] <= ext_w;
      mode_q[wr_ptr_q] <= q.in_mode;
    end
  end

  // The head slot drives the outputs; when empty it shows the stale last value.
  assign q.out_data  = data_q[rd_ptr_q];
  assign q.out_mode  = mode_q[rd_ptr_q];
  assign q.out_valid = (count_q != '0);
  assign q.in_ready  = in_ready_w;
  assign q.count     = count_q;

endmodule

// File: tb/tb_imm_extend_queue.sv
// Bench for imm_extend_queue: directed steps followed by a random phase,
// all checked against a queue-based reference model. A second instance with
// a 12-bit immediate and 24-bit operand covers the narrow build.
module tb_imm_extend_queue;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  logic rst2_n;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference queue entries: {mode, 32-bit operand}.
  logic [33:0] exp_q[$];
  logic        ready_en = 1'b0;

  imm_extend_queue_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) q1 ();
  imm_extend_queue_if #(.IN_W(12),   .OUT_W(24),    .CNT_W(4))     q2 ();

  imm_extend_queue #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q1)
  );

  imm_extend_queue #(.IN_W(12), .OUT_W(24), .DEPTH(2), .CNT_W(4)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .q     (q2)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Extension rules written as plain integer arithmetic.
  function automatic logic [31:0] ref_ext(input int in_w, input int out_w,
                                          input logic [31:0] imm, input logic [1:0] mode);
    longint one, u, s, r;
    one = 1;
    u = longint'(imm) & ((one << in_w) - 1);
    s = (u >= (one << (in_w - 1))) ? (u - (one << in_w)) : u;
    case (mode)
      2'd0:    r = s;
      2'd1:    r = u;
      2'd2:    r = s * 4;
      default: r = u * (one << (out_w - in_w));
    endcase
    return 32'(r & ((one << out_w) - 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle on dut: called at a negedge with inputs already driven.
  // Checks outputs against the model, then advances the model at posedge.
  task automatic cycle();
    logic        mr;
    logic        push;
    logic        pop;
    logic [33:0] head;
    #1;
    mr = ready_en && !q1.flush && (exp_q.size() < DEPTH);
    check("in_ready",  32'(q1.in_ready),  32'(mr));
    check("out_valid", 32'(q1.out_valid), 32'(exp_q.size() != 0));
    check("count",     32'(q1.count),     32'(exp_q.size()));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("out_data", q1.out_data,       head[31:0]);
      check("out_mode", 32'(q1.out_mode),  32'(head[33:32]));
    end
    push = q1.in_valid && mr;
    pop  = (exp_q.size() != 0) && q1.out_ready;
    @(posedge clk);
    ready_en = rst_n;
    if (!rst_n || q1.flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({q1.in_mode, ref_ext(IN_W, OUT_W, 32'(q1.in_imm), q1.in_mode)});
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic ordy, input logic fl);
    q1.in_valid  = v;
    q1.in_imm    = imm;
    q1.in_mode   = mode;
    q1.out_ready = ordy;
    q1.flush     = fl;
  endtask

  initial begin
    q1.in_valid = 1'b0; q1.in_imm = '0; q1.in_mode = '0; q1.out_ready = 1'b0; q1.flush = 1'b0;
    q2.in_valid = 1'b0; q2.in_imm = '0; q2.in_mode = '0; q2.out_ready = 1'b0; q2.flush = 1'b0;
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    #1;
    rst_n  = 1'b0;
    rst2_n = 1'b0;

    // Reset values while reset is held.
    @(negedge clk);
    check("rst_out_valid", 32'(q1.out_valid), 32'd0);
    check("rst_count",     32'(q1.count),     32'd0);
    check("rst_out_data",  q1.out_data,       32'd0);
    check("rst_out_mode",  32'(q1.out_mode),  32'd0);
    check("rst_in_ready",  32'(q1.in_ready),  32'd0);
    check("rst2_out_data", 32'(q2.out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // in_ready stays low until the first clock after release.
    cycle();

    // Scenario 1: sign-extend 0x8001.
    drive(1'b1, 16'h8001, 2'b00, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
    #1;
    check("s1_out_valid", 32'(q1.out_valid), 32'd1);
    check("s1_out_data",  q1.out_data,       32'hFFFF8001);
    check("s1_out_mode",  32'(q1.out_mode),  32'd0);
    check("s1_count",     32'(q1.count),     32'd1);
    cycle();

    // Scenario 2: the other modes on 0xF00C, one push per cycle.
    drive(1'b1, 16'hF00C, 2'b01, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 16'hF00C, 2'b10, 1'b1, 1'b0);
    #1 check("s2_zext", q1.out_data, 32'h0000F00C);
    cycle();
    drive(1'b1, 16'hF00C, 2'b11, 1'b1, 1'b0);
    #1 check("s2_brsh", q1.out_data, 32'hFFFFC030);
    cycle();
    drive(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
    #1 check("s2_upper", q1.out_data, 32'hF00C0000);
    cycle();
    cycle();

    // Scenario 3: fill with consumer stalled, third push held, then drain.
    drive(1'b1, 16'h1111, 2'b00, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'h2222, 2'b01, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'h3333, 2'b11, 1'b0, 1'b0);
    #1 check("s3_full_ready", 32'(q1.in_ready), 32'd0);
    cycle();
    cycle();
    drive(1'b1, 16'h3333, 2'b11, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle();

    // Scenario 4: hold occupancy at one with push+pop every cycle.
    drive(1'b1, 16'hA5A5, 2'b00, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'($urandom_range(0, 16'hFFFF)), 2'($urandom_range(0, 3)), 1'b1, 1'b0);
      cycle();
      check("s4_count", 32'(q1.count), 32'd1);
    end
    drive(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
    cycle();
    cycle();

    // Scenario 5: flush a full queue while a push is presented.
    drive(1'b1, 16'h0101, 2'b00, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'h0202, 2'b01, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'h7777, 2'b00, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
    #1;
    check("s5_count",     32'(q1.count),     32'd0);
    check("s5_out_valid", 32'(q1.out_valid), 32'd0);
    cycle();
    cycle();

    // Random phase.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
      cycle();
    end
    drive(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle();

    // Scenario 6: asynchronous reset with two entries queued.
    drive(1'b1, 16'h4444, 2'b00, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'h5555, 2'b01, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("s6_out_valid", 32'(q1.out_valid), 32'd0);
    check("s6_count",     32'(q1.count),     32'd0);
    check("s6_in_ready",  32'(q1.in_ready),  32'd0);
    exp_q.delete();
    ready_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q1.out_ready = 1'b1;
    cycle();
    drive(1'b1, 16'h0FF0, 2'b10, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
    cycle();
    cycle();

    // Narrow build: IN_W=12, OUT_W=24.
    rst2_n = 1'b1;
    @(negedge clk);
    q2.in_valid = 1'b1; q2.in_imm = 12'h801; q2.in_mode = 2'b00; q2.out_ready = 1'b1;
    @(negedge clk);
    q2.in_mode = 2'b10;
    #1;
    check("n_out_valid", 32'(q2.out_valid), 32'd1);
    check("n_sext",      32'(q2.out_data),  32'h00FFF801);
    check("n_count",     32'(q2.count),     32'd1);
    @(negedge clk);
    q2.in_mode = 2'b11;
    #1;
    check("n_brsh",       32'(q2.out_data), 32'h00FFE004);
    check("n_brsh_model", 32'(q2.out_data), ref_ext(12, 24, 32'h801, 2'b10));
    @(negedge clk);
    q2.in_valid = 1'b0;
    #1;
    check("n_upper",     32'(q2.out_data), 32'h00801000);
    check("n_upper_mode", 32'(q2.out_mode), 32'd3);
    @(negedge clk);
    #1 check("n_empty", 32'(q2.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
